rsa_job_sequencer: RTL and testbench
====================================

RSA_JOB_SEQUENCER -- requirements
Module: rsa_job_sequencer

Interface
REQ-001 SHALL have parameter WORD_LEN, default 512, operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 2**20, maximum cycles spent waiting in any single wrapper handshake.
REQ-003 SHALL have port clk  in  1  single clock; every flop on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports job_valid in 1 and job_ready out 1: job request and accept handshake.
REQ-006 SHALL have port job_mode  in  1  0 = exponentiation, 1 = multiplication.
REQ-007 SHALL have ports job_op0..job_op4  in  WORD_LEN each: exp order X,E,M,R2M,RM; mult order A,B,M (op3/op4 ignored).
REQ-008 SHALL have ports cmd_dout out 32, cmd_valid out 1, cmd_read in 1; these connect to wrapper port1_din/port1_valid/port1_read.
REQ-009 SHALL have ports done_valid in 1 and done_read out 1; these connect to wrapper port2_valid/port2_read.
REQ-010 SHALL have ports bram_din1 out WORD_LEN, bram_din_valid out 1, bram_dout1 in WORD_LEN, bram_dout1_valid in 1, bram_dout_read out 1.
REQ-011 SHALL have ports res_data out WORD_LEN, res_valid out 1, res_ready in 1, job_error out 1, busy out 1.

Function
REQ-012 SHALL assert job_ready only in IDLE; job_valid&job_ready SHALL latch mode and all operands and move to CMD with step=0.
REQ-013 SHALL issue the exp command table 0,1,2,3,4,7,8 and the mult table 0,1,2,5,6 in order, indexed by a step counter.
REQ-014 SHALL use states IDLE, CMD, DATA, WAIT_DONE, ACK, GRAB, OUT, ERR.
REQ-015 CMD: drive cmd_dout = table[step] with cmd_valid high; hold both until cmd_read is sampled high; cmd_valid SHALL drop the next cycle.
REQ-016 For load commands 0-4, DATA SHALL present op[cmd] on bram_din1 with bram_din_valid high for exactly one cycle, immediately after the cmd_read cycle.
REQ-017 For start commands 5/7, the sequencer SHALL go from CMD directly to WAIT_DONE.
REQ-018 For write commands 6/8, GRAB SHALL wait for bram_dout1_valid, capture bram_dout1 into the result register, and pulse bram_dout_read for one cycle.
REQ-019 WAIT_DONE/ACK: on sampling done_valid high, the sequencer SHALL assert done_read for exactly 2 cycles; then step++ and return to CMD, or go to OUT after the last step.
REQ-020 If done_valid and bram_dout1_valid rise in the same cycle during a write command, capture SHALL complete before done is acknowledged.
REQ-021 OUT SHALL hold res_valid and a stable res_data until res_ready; the res_valid&res_ready cycle SHALL return the FSM to IDLE.
REQ-022 A TIMEOUT-cycle counter SHALL restart on every state change; if it expires in CMD, WAIT_DONE or GRAB, the FSM SHALL enter ERR.
REQ-023 ERR SHALL drive job_error=1 and all wrapper strobes to 0, and SHALL leave only on reset.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 job_valid while busy SHALL be ignored and SHALL NOT corrupt latched operands.

Reset
REQ-026 When reset is high, the block SHALL go to IDLE, step=0, timer=0, and drive all outputs to 0 except job_ready, which SHALL be 1.
REQ-027 Reset asserted mid-job SHALL abort within one cycle, drop cmd_valid, done_read and bram strobes, and discard the partial result.

Structure
REQ-028 Package rsa_pkg SHALL hold the command codes (CMD_READ_OP0..4 = 0..4, CMD_START_MULT = 5, CMD_WRITE_MULT = 6, CMD_START_EXP = 7, CMD_WRITE_EXP = 8), the state enum, and the step-table constants.
REQ-029 The timeout counter SHALL be the sub-module rsa_watchdog (inputs clear/enable, output expired); everything else SHALL be inline.

Verification
REQ-030 Mult job with A=7, B=5, M=11 against a wrapper model: commands 0,1,2,5,6 observed in order, bram_din1 = 7,5,11, and the model result 0x23 appears on res_data with res_valid.
REQ-031 Exp job with X=2, E=0xA1, M=0x94...65: commands 0,1,2,3,4,7,8, exactly five bram_din_valid pulses, and res_data equals the model output.
REQ-032 Model delays cmd_read by 50 cycles: cmd_valid and cmd_dout stay stable throughout and no bram_din_valid is seen before the cmd_read cycle.
REQ-033 done_valid never asserted with TIMEOUT=64: job_error=1 at cycle 64 of WAIT_DONE and done_read stays 0.
REQ-034 reset pulsed during the WAIT_DONE of command 7: all strobes are 0 next cycle, job_ready=1, and a following mult job completes correctly.
REQ-035 res_ready held low for 20 cycles: res_valid and res_data stay stable, and job_ready stays 0 until the handshake.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job sequencer: wrapper command codes,
// FSM state encoding and the per-mode command step tables.
package rsa_pkg;

    typedef enum logic [3:0] {
        CMD_READ_OP0   = 4'd0,
        CMD_READ_OP1   = 4'd1,
        CMD_READ_OP2   = 4'd2,
        CMD_READ_OP3   = 4'd3,
        CMD_READ_OP4   = 4'd4,
        CMD_START_MULT = 4'd5,
        CMD_WRITE_MULT = 4'd6,
        CMD_START_EXP  = 4'd7,
        CMD_WRITE_EXP  = 4'd8
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        WAIT_DONE,
        ACK,
        GRAB,
        OUT,
        ERR
    } state_e;

    localparam int unsigned EXP_LEN  = 7;
    localparam int unsigned MULT_LEN = 5;

    // Entry [i] is the command issued at step i; unused upper slots are padding.
    localparam logic [7:0][3:0] EXP_TABLE = {
        4'd0, CMD_WRITE_EXP, CMD_START_EXP, CMD_READ_OP4,
        CMD_READ_OP3, CMD_READ_OP2, CMD_READ_OP1, CMD_READ_OP0
    };
    localparam logic [7:0][3:0] MULT_TABLE = {
        4'd0, 4'd0, 4'd0, CMD_WRITE_MULT,
        CMD_START_MULT, CMD_READ_OP2, CMD_READ_OP1, CMD_READ_OP0
    };

    function automatic cmd_e step_cmd(input logic mode, input logic [2:0] step);
        return cmd_e'(mode ? MULT_TABLE[step] : EXP_TABLE[step]);
    endfunction

    function automatic logic is_last_step(input logic mode, input logic [2:0] step);
        return mode ? (step == 3'(MULT_LEN - 1)) : (step == 3'(EXP_LEN - 1));
    endfunction

    function automatic logic is_load(input cmd_e c);
        return c inside {CMD_READ_OP0, CMD_READ_OP1, CMD_READ_OP2, CMD_READ_OP3, CMD_READ_OP4};
    endfunction

    function automatic logic is_start(input cmd_e c);
        return (c == CMD_START_MULT) || (c == CMD_START_EXP);
    endfunction

endpackage

// File: rtl/rsa_job_sequencer_if.sv
// Wrapper-side bus of the sequencer: command port, done handshake and
// BRAM data in/out strobes. master = sequencer, slave = RSA wrapper.
interface rsa_job_sequencer_if
    import rsa_pkg::*;
#(
    parameter int unsigned WORD_LEN = 512
);
    logic [31:0]         cmd_dout;
    logic                cmd_valid;
    logic                cmd_read;
    logic                done_valid;
    logic                done_read;
    logic [WORD_LEN-1:0] bram_din1;
    logic                bram_din_valid;
    logic [WORD_LEN-1:0] bram_dout1;
    logic                bram_dout1_valid;
    logic                bram_dout_read;

    modport master (
        output cmd_dout, cmd_valid,
        input  cmd_read,
        input  done_valid,
        output done_read,
        output bram_din1, bram_din_valid,
        input  bram_dout1, bram_dout1_valid,
        output bram_dout_read
    );

    modport slave (
        input  cmd_dout, cmd_valid,
        output cmd_read,
        output done_valid,
        input  done_read,
        input  bram_din1, bram_din_valid,
        output bram_dout1, bram_dout1_valid,
        input  bram_dout_read
    );
endinterface

// File: rtl/rsa_watchdog.sv
// Per-state handshake timer: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT cycles have been spent in the current state.
module rsa_watchdog
    import rsa_pkg::*;
#(
    parameter int unsigned TIMEOUT = 2**20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    // Expiry is seen on the TIMEOUT-th cycle so the FSM leaves right after it.
    assign expired = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/rsa_job_sequencer.sv
// Sequences one exponentiation or multiplication job through the RSA
// wrapper's command/data/done ports and returns the captured result.
module rsa_job_sequencer
    import rsa_pkg::*;
#(
    parameter int unsigned WORD_LEN = 512,
    parameter int unsigned TIMEOUT  = 2**20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic                 job_mode,
    input  logic [WORD_LEN-1:0]  job_op0,
    input  logic [WORD_LEN-1:0]  job_op1,
    input  logic [WORD_LEN-1:0]  job_op2,
    input  logic [WORD_LEN-1:0]  job_op3,
    input  logic [WORD_LEN-1:0]  job_op4,
    rsa_job_sequencer_if.master  wrap,
    output logic [WORD_LEN-1:0]  res_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 job_error,
    output logic                 busy
);
    state_e              state, state_next;
    logic [2:0]          step;
    logic                mode;
    logic [WORD_LEN-1:0] ops [5];
    logic [WORD_LEN-1:0] result;
    logic                ack_second;
    cmd_e                cur_cmd;
    logic [3:0]          cmd_code;
    logic                wd_enable;
    logic                wd_expired;
    logic                last_step;

    assign cur_cmd   = step_cmd(mode, step);
    assign cmd_code  = cur_cmd;
    assign last_step = is_last_step(mode, step);

    rsa_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_next != state),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        job_ready           = 1'b0;
        res_valid           = 1'b0;
        job_error           = 1'b0;
        wd_enable           = 1'b0;
        wrap.cmd_valid      = 1'b0;
        wrap.cmd_dout       = '0;
        wrap.bram_din_valid = 1'b0;
        wrap.bram_din1      = '0;
        wrap.bram_dout_read = 1'b0;
        wrap.done_read      = 1'b0;

        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                wd_enable     = 1'b1;
                wrap.cmd_valid = 1'b1;
                wrap.cmd_dout  = {28'd0, cmd_code};
                if (wrap.cmd_read) begin
                    if (is_load(cur_cmd)) begin
                        state_next = DATA;
                    end else if (is_start(cur_cmd)) begin
                        state_next = WAIT_DONE;
                    end else begin
                        state_next = GRAB;
                    end
                end else if (wd_expired) begin
                    state_next = ERR;
                end
            end
            DATA: begin
                wrap.bram_din_valid = 1'b1;
                wrap.bram_din1      = ops[cmd_code[2:0]];
                state_next          = WAIT_DONE;
            end
            WAIT_DONE: begin
                wd_enable = 1'b1;
                if (wrap.done_valid) begin
                    state_next = ACK;
                end else if (wd_expired) begin
                    state_next = ERR;
                end
            end
            ACK: begin
                wrap.done_read = 1'b1;
                if (ack_second) begin
                    state_next = last_step ? OUT : CMD;
                end
            end
            // Capture comes first; a done raised alongside the data is
            // picked up once WAIT_DONE is re-entered.
            GRAB: begin
                wd_enable = 1'b1;
                if (wrap.bram_dout1_valid) begin
                    wrap.bram_dout_read = 1'b1;
                    state_next          = WAIT_DONE;
                end else if (wd_expired) begin
                    state_next = ERR;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            ERR: begin
                job_error = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign res_data = (state == OUT) ? result : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            step       <= '0;
            mode       <= 1'b0;
            result     <= '0;
            ack_second <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) begin
                ops[i] <= '0;
            end
        end else begin
            ack_second <= (state == ACK) && !ack_second;
            if (state == IDLE && job_valid) begin
                mode   <= job_mode;
                step   <= '0;
                ops[0] <= job_op0;
                ops[1] <= job_op1;
                ops[2] <= job_op2;
                ops[3] <= job_op3;
                ops[4] <= job_op4;
            end
            if (state == ACK && ack_second && !last_step) begin
                step <= step + 3'd1;
            end
            if (state == GRAB && wrap.bram_dout1_valid) begin
                result <= wrap.bram_dout1;
            end
        end
    end
endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Scoreboard bench: a wrapper model answers the sequencer, expected commands,
// operands and results are queued at job submission and checked on arrival.
module tb_rsa_job_sequencer;
    localparam int unsigned W = 512;

    logic         clk, reset;
    logic         job_valid, job_ready, job_mode;
    logic [W-1:0] job_op0, job_op1, job_op2, job_op3, job_op4;
    logic [W-1:0] res_data;
    logic         res_valid, res_ready, job_error, busy;

    rsa_job_sequencer_if #(.WORD_LEN(W)) wif ();

    rsa_job_sequencer #(
        .WORD_LEN (W),
        .TIMEOUT  (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_mode  (job_mode),
        .job_op0   (job_op0),
        .job_op1   (job_op1),
        .job_op2   (job_op2),
        .job_op3   (job_op3),
        .job_op4   (job_op4),
        .wrap      (wif),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .job_error (job_error),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mult_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_exp(input logic [W-1:0] x, input logic [W-1:0] e,
                                             input logic [W-1:0] m);
        logic [2*W-1:0] r, b, mm;
        mm = {{W{1'b0}}, m};
        r  = 1;
        b  = {{W{1'b0}}, x} % mm;
        for (int i = 0; i < int'(W); i++) begin
            if (e[i]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return r[W-1:0];
    endfunction

    // Scoreboard queues and wrapper-model state
    int           exp_cmd_q[$];
    logic [W-1:0] exp_din_q[$];
    logic [W-1:0] exp_res_q[$];
    logic [W-1:0] mdl_ops [5];
    logic [W-1:0] mdl_res;
    logic [31:0]  cmd_first;
    int           cur_cmd;
    int           cmd_wait, cmd_delay, done_delay, done_cnt, dr_len;
    int           din_pulses, dout_reads;
    bit           din_due, dout_drop, done_enable, stall7;

    initial begin : wrapper_model
        wif.cmd_read = 1'b0;
        wif.done_valid = 1'b0;
        wif.bram_dout1 = '0;
        wif.bram_dout1_valid = 1'b0;
        cmd_delay = 2; done_delay = 3; done_enable = 1; stall7 = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wif.cmd_read = 1'b0;
                wif.done_valid = 1'b0;
                wif.bram_dout1 = '0;
                wif.bram_dout1_valid = 1'b0;
                exp_cmd_q.delete(); exp_din_q.delete(); exp_res_q.delete();
                cmd_wait = 0; din_due = 0; done_cnt = -1; dout_drop = 0; dr_len = 0;
                cur_cmd = 0;
            end else begin
                if (wif.done_read) dr_len++;
                else if (dr_len != 0) begin
                    check_val("done_read_len", W'(dr_len), W'(2));
                    dr_len = 0;
                end
                if (dout_drop) begin
                    wif.bram_dout1_valid = 1'b0;
                    wif.bram_dout1 = '0;
                    dout_drop = 0;
                end
                if (wif.bram_dout_read) begin
                    dout_reads++;
                    dout_drop = 1;
                end
                if (wif.done_read) wif.done_valid = 1'b0;
                if (done_cnt > 0) done_cnt--;
                else if (done_cnt == 0) begin
                    wif.done_valid = done_enable && !(stall7 && cur_cmd == 7);
                    done_cnt = -1;
                end
                if (din_due) begin
                    check_val("din_valid_after_read", W'(wif.bram_din_valid), W'(1));
                    if (wif.bram_din_valid) begin
                        din_pulses++;
                        if (exp_din_q.size() != 0) check_val("bram_din1", wif.bram_din1, exp_din_q.pop_front());
                        if (cur_cmd < 5) mdl_ops[cur_cmd] = wif.bram_din1;
                        done_cnt = done_delay;
                    end
                    din_due = 0;
                end else if (wif.bram_din_valid) begin
                    check_val("din_valid_unexpected", W'(wif.bram_din_valid), W'(0));
                end
                if (wif.cmd_read) begin
                    wif.cmd_read = 1'b0;
                end else if (wif.cmd_valid) begin
                    if (cmd_wait == 0) cmd_first = wif.cmd_dout;
                    else check_val("cmd_dout_stable", W'(wif.cmd_dout), W'(cmd_first));
                    if (cmd_wait >= cmd_delay) begin
                        wif.cmd_read = 1'b1;
                        cmd_wait = 0;
                        cur_cmd = int'(wif.cmd_dout);
                        if (exp_cmd_q.size() != 0) check_val("cmd_order", W'(wif.cmd_dout), W'(exp_cmd_q.pop_front()));
                        else check_val("cmd_unexpected", W'(wif.cmd_valid), W'(0));
                        if (cur_cmd <= 4) begin
                            din_due = 1;
                        end else if (cur_cmd == 5 || cur_cmd == 7) begin
                            mdl_res = (cur_cmd == 7) ? mod_exp(mdl_ops[0], mdl_ops[1], mdl_ops[2])
                                                     : mult_model(mdl_ops[0], mdl_ops[1]);
                            done_cnt = done_delay;
                        end else begin
                            wif.bram_dout1 = mdl_res;
                            wif.bram_dout1_valid = 1'b1;
                            wif.done_valid = done_enable;
                        end
                    end else begin
                        cmd_wait++;
                    end
                end else if (cmd_wait != 0) begin
                    check_val("cmd_valid_held", W'(wif.cmd_valid), W'(1));
                    cmd_wait = 0;
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input logic mode, input logic [W-1:0] o0, input logic [W-1:0] o1,
                             input logic [W-1:0] o2, input logic [W-1:0] o3,
                             input logic [W-1:0] o4, input bit spam);
        int n;
        n = 0;
        while (!job_ready && n < 2000) begin tick(); n++; end
        check_val("job_ready_before_start", W'(job_ready), W'(1));
        if (mode) begin
            exp_cmd_q = '{0, 1, 2, 5, 6};
            exp_din_q = '{o0, o1, o2};
            exp_res_q.push_back(mult_model(o0, o1));
        end else begin
            exp_cmd_q = '{0, 1, 2, 3, 4, 7, 8};
            exp_din_q = '{o0, o1, o2, o3, o4};
            exp_res_q.push_back(mod_exp(o0, o1, o2));
        end
        din_pulses = 0;
        dout_reads = 0;
        job_mode = mode;
        job_op0 = o0; job_op1 = o1; job_op2 = o2; job_op3 = o3; job_op4 = o4;
        job_valid = 1'b1;
        tick();
        check_val("busy_after_accept", W'(busy), W'(1));
        check_val("job_ready_after_accept", W'(job_ready), W'(0));
        if (spam) begin
            job_op0 = ~o0; job_op1 = ~o1; job_op2 = ~o2; job_op3 = ~o3; job_op4 = ~o4;
            job_mode = ~mode;
            repeat (8) begin
                tick();
                check_val("job_ready_while_busy", W'(job_ready), W'(0));
            end
        end
        job_valid = 1'b0;
    endtask

    task automatic finish_job(input logic mode, input int hold);
        int n;
        logic [W-1:0] first, exp;
        n = 0;
        while (!res_valid && n < 20000) begin tick(); n++; end
        check_val("res_valid_seen", W'(res_valid), W'(1));
        if (res_valid) begin
            first = res_data;
            repeat (hold) begin
                tick();
                check_val("res_valid_hold", W'(res_valid), W'(1));
                check_val("res_data_hold", res_data, first);
                check_val("job_ready_in_out", W'(job_ready), W'(0));
            end
            exp = (exp_res_q.size() != 0) ? exp_res_q.pop_front() : 'x;
            check_val("res_data", res_data, exp);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check_val("job_ready_after_out", W'(job_ready), W'(1));
            check_val("res_valid_after_out", W'(res_valid), W'(0));
            check_val("busy_after_out", W'(busy), W'(0));
            check_val("din_pulses", W'(din_pulses), mode ? W'(3) : W'(5));
            check_val("dout_reads", W'(dout_reads), W'(1));
            check_val("cmds_left", W'(exp_cmd_q.size()), W'(0));
            check_val("job_error_ok", W'(job_error), W'(0));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_job_ready"}, W'(job_ready), W'(1));
        check_val({tag, "_busy"}, W'(busy), W'(0));
        check_val({tag, "_cmd_valid"}, W'(wif.cmd_valid), W'(0));
        check_val({tag, "_done_read"}, W'(wif.done_read), W'(0));
        check_val({tag, "_din_valid"}, W'(wif.bram_din_valid), W'(0));
        check_val({tag, "_dout_read"}, W'(wif.bram_dout_read), W'(0));
        check_val({tag, "_res_valid"}, W'(res_valid), W'(0));
        check_val({tag, "_res_data"}, res_data, '0);
        check_val({tag, "_job_error"}, W'(job_error), W'(0));
    endtask

    logic [W-1:0] big_m;
    bit           any_dr;

    initial begin : main
        int n;
        reset = 1'b1; job_valid = 1'b0; job_mode = 1'b0; res_ready = 1'b0;
        job_op0 = '0; job_op1 = '0; job_op2 = '0; job_op3 = '0; job_op4 = '0;
        big_m = {8'h94, {62{8'h3c}}, 8'h65};
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic multiplication
        start_job(1'b1, W'(7), W'(5), W'(11), '0, '0, 1'b0);
        finish_job(1'b1, 0);

        // Exponentiation with a full-width modulus
        start_job(1'b0, W'(2), W'('hA1), big_m, W'('h1234), W'('h5678), 1'b0);
        finish_job(1'b0, 0);

        // Slow cmd_read and a stalled result consumer
        cmd_delay = 50;
        start_job(1'b0, W'(3), W'('h11), W'('hF1), W'('hAB), W'('hCD), 1'b0);
        finish_job(1'b0, 20);
        cmd_delay = 2;

        // Job requests while busy must not disturb the latched job
        start_job(1'b1, W'(48'hFFFF_FFFF_FFFF), W'(17'h1_0001), W'(1), '0, '0, 1'b1);
        finish_job(1'b1, 3);

        // No done ever: expiry after 64 cycles in WAIT_DONE
        done_enable = 0;
        start_job(1'b0, W'(5), W'(3), W'(7), '0, '0, 1'b0);
        n = 0;
        while (!wif.bram_din_valid && n < 500) begin tick(); n++; end
        check_val("first_din_seen", W'(wif.bram_din_valid), W'(1));
        any_dr = 0;
        repeat (64) begin
            tick();
            if (wif.done_read) any_dr = 1;
        end
        check_val("job_error_before_expiry", W'(job_error), W'(0));
        tick();
        if (wif.done_read) any_dr = 1;
        check_val("job_error_at_expiry", W'(job_error), W'(1));
        repeat (5) begin
            tick();
            if (wif.done_read) any_dr = 1;
        end
        check_val("err_sticky", W'(job_error), W'(1));
        check_val("err_busy", W'(busy), W'(1));
        check_val("err_cmd_valid", W'(wif.cmd_valid), W'(0));
        check_val("err_no_done_read", W'(any_dr), W'(0));
        reset = 1'b1;
        tick();
        check_idle_outputs("err_reset");
        reset = 1'b0;
        done_enable = 1;

        // Reset while waiting for done of the exp start command
        stall7 = 1;
        start_job(1'b0, W'(2), W'(9), W'(101), W'(4), W'(6), 1'b0);
        n = 0;
        while (!(wif.cmd_read && wif.cmd_dout == 32'd7) && n < 2000) begin tick(); n++; end
        check_val("cmd7_read_seen", W'(wif.cmd_dout), W'(7));
        repeat (5) tick();
        check_val("waiting_cmd7_busy", W'(busy), W'(1));
        reset = 1'b1;
        tick();
        check_idle_outputs("midjob_reset");
        reset = 1'b0;
        stall7 = 0;
        tick();

        start_job(1'b1, W'(9), W'(13), W'(23), '0, '0, 1'b0);
        finish_job(1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : global_bound
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end
endmodule
